// File: rtl/ringbuffer_drain.sv
// Drains ring-buffer entries one at a time and serialises each one as a UART frame:
// a header byte carrying a sticky overflow ("lost") flag, followed by the entry bytes MSB first.
module ringbuffer_drain #(
   parameter int         DW  = 48,
   parameter logic [7:0] HDR = 8'hA4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          empty,
   input  logic          overflow,
   input  logic [DW-1:0] read_data,
   output logic          read_clock_enable,
   output logic [7:0]    uart_data,
   output logic          uart_start,
   input  logic          uart_busy,
   output logic          busy,
   output logic [15:0]   frames_sent
);

   localparam int            NBYTES   = DW / 8;
   localparam int            IW       = $clog2(NBYTES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES);

   if ((DW % 8) != 0 || DW < 8 || DW > 64) begin : gBadDw
      $error("ringbuffer_drain: DW must be a multiple of 8 in 8..64");
   end
   if (HDR[1:0] != 2'b00) begin : gBadHdr
      $error("ringbuffer_drain: HDR[1:0] must be zero");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      SEND  = 3'd3,
      ACK   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   shiftReg_q, shiftReg_d;
   logic [IW-1:0]   byteIdx_q, byteIdx_d;
   logic            lost_q, lost_d;
   logic [7:0]      uartData_q, uartData_d;
   logic [15:0]     framesSent_q;
   logic [7:0]      header;
   logic [7:0]      curByte;
   logic            readEn;
   logic            strobe;
   logic            frameDone;

   assign header  = HDR | {7'b0, lost_q};
   assign curByte = (byteIdx_q == '0) ? header : shiftReg_q[DW-1 -: 8];

   // Next-state logic. Data bytes always come from the top of the shift register,
   // which moves up one byte after each data strobe.
   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      byteIdx_d  = byteIdx_q;
      lost_d     = lost_q | overflow;
      uartData_d = uartData_q;
      readEn     = 1'b0;
      strobe     = 1'b0;
      frameDone  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               readEn  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = LATCH;
         end
         LATCH: begin
            shiftReg_d = read_data;
            byteIdx_d  = '0;
            state_d    = SEND;
         end
         SEND: begin
            if (!uart_busy) begin
               strobe     = 1'b1;
               uartData_d = curByte;
               state_d    = ACK;
               if (byteIdx_q == '0) begin
                  // An overflow on the header cycle itself must survive into the next frame.
                  lost_d = overflow;
               end else begin
                  shiftReg_d = shiftReg_q << 8;
               end
            end
         end
         ACK: begin
            if (byteIdx_q == LAST_IDX) begin
               frameDone = 1'b1;
               state_d   = IDLE;
            end else begin
               byteIdx_d = byteIdx_q + 1'b1;
               state_d   = SEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         shiftReg_q   <= '0;
         byteIdx_q    <= '0;
         lost_q       <= 1'b0;
         uartData_q   <= 8'h00;
         framesSent_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         shiftReg_q <= shiftReg_d;
         byteIdx_q  <= byteIdx_d;
         lost_q     <= lost_d;
         uartData_q <= uartData_d;
         if (frameDone && framesSent_q != 16'hFFFF) begin
            framesSent_q <= framesSent_q + 16'd1;
         end
      end
   end

   // Strobes are gated by reset so an asserted reset silences them immediately.
   assign read_clock_enable = readEn & reset;
   assign uart_start        = strobe & reset;
   assign uart_data         = strobe ? curByte : uartData_q;
   assign busy              = (state_q != IDLE);
   assign frames_sent       = framesSent_q;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Bench for ringbuffer_drain: a queue-based buffer and UART model drive the DUT, and a
// monitor scores every strobed byte against the entries that were queued.
`timescale 1ns/1ps
module tb_ringbuffer_drain;

   localparam int         DW  = 48;
   localparam int         NB  = DW / 8;
   localparam logic [7:0] HDR = 8'hA4;

   logic          clock = 1'b1;
   logic          reset;
   logic          empty;
   logic          overflow;
   logic [DW-1:0] readData;
   logic          readClockEnable;
   logic [7:0]    uartData;
   logic          uartStart;
   logic          uartBusy;
   logic          busy;
   logic [15:0]   framesSent;

   int checks        = 0;
   int failures      = 0;
   int pops          = 0;
   int strobes       = 0;
   int pos           = 0;
   int busyCycles    = 0;
   int expFramesSent = 0;

   logic [DW-1:0] bufQ[$];
   logic [DW-1:0] expFrames[$];
   logic [7:0]    hdrSeen[$];

   ringbuffer_drain #(.DW(DW), .HDR(HDR)) dut (
      .clock             (clock),
      .reset             (reset),
      .empty             (empty),
      .overflow          (overflow),
      .read_data         (readData),
      .read_clock_enable (readClockEnable),
      .uart_data         (uartData),
      .uart_start        (uartStart),
      .uart_busy         (uartBusy),
      .busy              (busy),
      .frames_sent       (framesSent)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s", name);
   endtask

   // Queue an entry in the buffer and record it as the next expected frame.
   task automatic applyStimulus(input logic [DW-1:0] entry);
      bufQ.push_back(entry);
      expFrames.push_back(entry);
      expFramesSent++;
   endtask

   function automatic logic [DW-1:0] randEntry();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   // Byte k (1 = most significant) of an entry.
   function automatic logic [7:0] byteOf(input logic [DW-1:0] e, input int k);
      logic [DW-1:0] t;
      t = e >> (8 * (NB - k));
      return t[7:0];
   endfunction

   task automatic stepCycle();
      @(negedge clock);
      #1;
   endtask

   task automatic waitDone(input int budget, input bit randOvf);
      int n;
      n = 0;
      while ((expFrames.size() != 0 || bufQ.size() != 0 || busy) && n < budget) begin
         stepCycle();
         if (randOvf) overflow = ($urandom_range(0, 7) == 0);
         n++;
      end
      overflow = 1'b0;
      if (n >= budget) failNow("wait_timeout");
   endtask

   // Buffer model: a pop requested in one cycle updates read data and empty just after that cycle's edge.
   initial begin : bufferModel
      bit popReq;
      empty    = 1'b1;
      readData = '0;
      forever begin
         @(posedge clock);
         popReq = readClockEnable;
         stepCycle();
         if (popReq) begin
            if (bufQ.size() != 0) readData = bufQ.pop_front();
            else failNow("pop_while_empty");
         end
         empty = (bufQ.size() == 0);
      end
   end

   // UART model: busy for busyCycles cycles after each accepted strobe.
   initial begin : uartModel
      bit st;
      int remain;
      remain   = 0;
      uartBusy = 1'b0;
      forever begin
         @(posedge clock);
         st = uartStart;
         stepCycle();
         if (remain > 0) remain--;
         if (st && busyCycles > 0) remain = busyCycles;
         uartBusy = (remain > 0);
      end
   end

   // Monitor: scores strobes, protocol rules and the sticky lost flag, cycle by cycle.
   initial begin : monitor
      bit         prevStart;
      bit         hdrStrobe;
      logic [7:0] lastByte;
      logic [7:0] expByte;
      logic       lostModel;
      prevStart = 1'b0;
      lastByte  = 8'h00;
      lostModel = 1'b0;
      forever begin
         @(posedge clock);
         if (!reset) begin
            if (pos != 0 && expFrames.size() != 0) void'(expFrames.pop_front());
            pos       = 0;
            prevStart = 1'b0;
            lastByte  = 8'h00;
            lostModel = 1'b0;
         end else begin
            hdrStrobe = uartStart && (pos == 0);
            if (readClockEnable) begin
               pops++;
               checkOutput("pop_outside_idle", 64'(busy), 64'(0));
            end
            if (uartStart) begin
               strobes++;
               checkOutput("start_while_uart_busy", 64'(uartBusy), 64'(0));
               checkOutput("start_back_to_back", 64'(prevStart), 64'(0));
               if (expFrames.size() == 0) begin
                  failNow("unexpected_strobe");
               end else begin
                  if (pos == 0) expByte = HDR | {7'b0, lostModel};
                  else          expByte = byteOf(expFrames[0], pos);
                  checkOutput((pos == 0) ? "header_byte" : "data_byte", 64'(uartData), 64'(expByte));
                  if (pos == 0) hdrSeen.push_back(uartData);
                  lastByte = expByte;
                  if (pos == NB) begin
                     pos = 0;
                     void'(expFrames.pop_front());
                  end else begin
                     pos++;
                  end
               end
            end else begin
               checkOutput("uart_data_hold", 64'(uartData), 64'(lastByte));
            end
            prevStart = uartStart;
            lostModel = overflow ? 1'b1 : (hdrStrobe ? 1'b0 : lostModel);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] timeout");
   end

   initial begin : mainSeq
      int s0;
      int p0;
      int n;
      int nEnt;
      reset    = 1'b0;
      overflow = 1'b0;

      // Reset state, with an entry already waiting in the buffer.
      stepCycle();
      applyStimulus(48'h0123_4567_89AB);
      repeat (3) stepCycle();
      checkOutput("reset_rce", 64'(readClockEnable), 64'(0));
      checkOutput("reset_start", 64'(uartStart), 64'(0));
      checkOutput("reset_data", 64'(uartData), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_frames", 64'(framesSent), 64'(0));
      reset = 1'b1;

      // Single entry, no back-pressure.
      waitDone(2000, 1'b0);
      checkOutput("single_frames", 64'(framesSent), 64'(1));
      checkOutput("single_busy", 64'(busy), 64'(0));
      checkOutput("single_pops", 64'(pops), 64'(1));
      checkOutput("single_strobes", 64'(strobes), 64'(7));
      checkOutput("single_header", 64'(hdrSeen[0]), 64'(8'hA4));

      // Back-pressure: UART busy for 20 cycles after each strobe.
      busyCycles = 20;
      s0 = strobes;
      applyStimulus(48'h0123_4567_89AB);
      waitDone(4000, 1'b0);
      checkOutput("bp_frames", 64'(framesSent), 64'(2));
      checkOutput("bp_strobes", 64'(strobes - s0), 64'(7));
      checkOutput("bp_header", 64'(hdrSeen[1]), 64'(8'hA4));
      busyCycles = 0;

      // Overflow during frame N's data bytes flags frame N+1 only.
      applyStimulus(randEntry());
      n = 0;
      while (!(pos >= 2 && pos < NB) && n < 500) begin
         stepCycle();
         n++;
      end
      if (n >= 500) failNow("ovf_wait_timeout");
      overflow = 1'b1;
      repeat (3) stepCycle();
      overflow = 1'b0;
      waitDone(2000, 1'b0);
      applyStimulus(randEntry());
      waitDone(2000, 1'b0);
      applyStimulus(randEntry());
      waitDone(2000, 1'b0);
      checkOutput("ovf_hdr_n", 64'(hdrSeen[2]), 64'(8'hA4));
      checkOutput("ovf_hdr_n1", 64'(hdrSeen[3]), 64'(8'hA5));
      checkOutput("ovf_hdr_n2", 64'(hdrSeen[4]), 64'(8'hA4));
      checkOutput("ovf_frames", 64'(framesSent), 64'(5));

      // Back-to-back: four queued entries.
      s0 = strobes;
      p0 = pops;
      repeat (4) applyStimulus(randEntry());
      waitDone(2000, 1'b0);
      checkOutput("b2b_pops", 64'(pops - p0), 64'(4));
      checkOutput("b2b_strobes", 64'(strobes - s0), 64'(28));
      checkOutput("b2b_frames", 64'(framesSent), 64'(9));

      // Randomised traffic, back-pressure and overflow pulses.
      for (int i = 0; i < 6; i++) begin
         busyCycles = $urandom_range(0, 3);
         nEnt = $urandom_range(1, 2);
         for (int j = 0; j < nEnt; j++) applyStimulus(randEntry());
         waitDone(3000, 1'b1);
      end
      checkOutput("rand_frames", 64'(framesSent), 64'(expFramesSent));
      busyCycles = 0;
      repeat (5) stepCycle();

      // Reset asserted after the third strobe of a frame.
      applyStimulus(randEntry());
      n = 0;
      while (pos < 3 && n < 500) begin
         stepCycle();
         n++;
      end
      if (n >= 500) failNow("rst_wait_timeout");
      reset = 1'b0;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'(0));
      checkOutput("midrst_data", 64'(uartData), 64'(0));
      checkOutput("midrst_start", 64'(uartStart), 64'(0));
      checkOutput("midrst_rce", 64'(readClockEnable), 64'(0));
      checkOutput("midrst_frames", 64'(framesSent), 64'(0));
      expFramesSent = 0;
      s0 = strobes;
      p0 = pops;
      repeat (3) stepCycle();
      reset = 1'b1;
      repeat (30) stepCycle();
      checkOutput("postrst_strobes", 64'(strobes - s0), 64'(0));
      checkOutput("postrst_pops", 64'(pops - p0), 64'(0));
      checkOutput("postrst_frames", 64'(framesSent), 64'(0));
      checkOutput("postrst_busy", 64'(busy), 64'(0));

      // Saturation of the frame counter.
      force dut.framesSent_q = 16'hFFFE;
      #1;
      release dut.framesSent_q;
      stepCycle();
      applyStimulus(randEntry());
      waitDone(2000, 1'b0);
      checkOutput("sat_first", 64'(framesSent), 64'(16'hFFFF));
      applyStimulus(randEntry());
      applyStimulus(randEntry());
      waitDone(2000, 1'b0);
      checkOutput("sat_final", 64'(framesSent), 64'(16'hFFFF));

      repeat (3) stepCycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
